program_sequencer: RTL and testbench

Instruction-side front end for the DSP core: fetches 16-bit program words from synchronous program memory, assembles one- and two-word instructions, and issues them to the control decode LUT. The decode LUT consumes the issued word directly, along with its 8-bit and 4-bit opcode fields. The sequencer also executes the PC-select decision (`pcInMux_ctrl`) returned by execute. With the stack compiled in, it maintains a 4-level hardware return stack for call/return.

---
 rtl/dsp_pkg.sv | 36 +++
 rtl/return_stack.sv | 49 ++++
 rtl/program_sequencer.sv | 144 ++++++++++++++
 tb/tb_program_sequencer.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_pkg.sv
// Shared DSP front-end definitions: sequencer states, PC-select codes, opcode constants.
// The return stack is built only when HW_STACK_EN is defined.
package dsp_pkg;

    localparam int unsigned DEFAULT_PC_W        = 12;
    localparam int unsigned DEFAULT_STACK_DEPTH = 4;
    localparam int unsigned INSTR_W             = 16;

    typedef enum logic [2:0] {
        FETCH,
        CAPTURE,
        OPFETCH,
        OPCAPTURE,
        ISSUE
    } seq_state_t;

    // pcInMux_ctrl encodings returned by execute
    localparam logic [1:0] PC_SEL_SEQ     = 2'b00;
    localparam logic [1:0] PC_SEL_OPERAND = 2'b01;
    localparam logic [1:0] PC_SEL_ACC     = 2'b10;
    localparam logic [1:0] PC_SEL_STACK   = 2'b11;

    // Branch/call group carries a second program word
    localparam logic [3:0] OP_CLASS_BRANCH = 4'b1111;

    localparam logic [7:0] OP_ADD  = 8'h00;
    localparam logic [7:0] OP_RET  = 8'hE0;
    localparam logic [7:0] OP_BR   = 8'hF1;
    localparam logic [7:0] OP_CALL = 8'hF8;
    localparam logic [7:0] OP_CBR  = 8'hF9;

    function automatic logic is_two_word(input logic [INSTR_W-1:0] word);
        return word[15:12] == OP_CLASS_BRANCH;
    endfunction

endpackage

// File: rtl/return_stack.sv
// Shift-style return-address LIFO; err is sticky on overflow/underflow until reset.
module return_stack
    import dsp_pkg::*;
#(
    parameter int unsigned W     = DEFAULT_PC_W,
    parameter int unsigned DEPTH = DEFAULT_STACK_DEPTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_data,
    output logic [W-1:0] top_c,
    output logic         err
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]     entries [DEPTH];
    logic [CNT_W-1:0] depth;

    // Popping an empty stack yields address 0
    assign top_c = (depth == '0) ? '0 : entries[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            depth <= '0;
            err   <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) entries[i] <= '0;
        end else if (push && pop) begin
            // top was already read as the pop target; replace it in place
            entries[0] <= push_data;
        end else if (push) begin
            for (int i = int'(DEPTH) - 1; i > 0; i--) entries[i] <= entries[i-1];
            entries[0] <= push_data;
            if (depth == CNT_W'(DEPTH)) err <= 1'b1;
            else                        depth <= depth + CNT_W'(1);
        end else if (pop) begin
            if (depth == '0) begin
                err <= 1'b1;
            end else begin
                for (int i = 0; i < int'(DEPTH) - 1; i++) entries[i] <= entries[i+1];
                entries[DEPTH-1] <= '0;
                depth <= depth - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/program_sequencer.sv
// Instruction fetch/assemble/issue front end with PC-select execution.
// Optional hardware return stack enabled by defining HW_STACK_EN.
module program_sequencer
    import dsp_pkg::*;
#(
    parameter int unsigned PC_W        = DEFAULT_PC_W,
    parameter int unsigned STACK_DEPTH = DEFAULT_STACK_DEPTH
) (
    input  logic            clk,
    input  logic            reset,
    output logic [PC_W-1:0] pm_addr,
    output logic            pm_rd,
    input  logic [15:0]     pm_data,
    output logic [15:0]     instruction,
    output logic [7:0]      OP_dk,
    output logic [3:0]      OP_s,
    output logic [15:0]     operand,
    output logic            instr_valid,
    input  logic            stall,
    input  logic            redirect,
    input  logic [1:0]      pcInMux_ctrl,
    input  logic [PC_W-1:0] acc_low,
    input  logic            push_ret,
    output logic            stack_err
);

    seq_state_t      state;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] next_pc;
    logic            consume;

    assign consume = (state == ISSUE) && !stall;
    assign OP_dk   = instruction[15:8];
    assign OP_s    = instruction[15:12];

`ifdef HW_STACK_EN
    logic [PC_W-1:0] stack_top;
    logic            do_push;
    logic            do_pop;

    assign do_push = consume && push_ret;
    assign do_pop  = consume && redirect && (pcInMux_ctrl == PC_SEL_STACK);

    // Return address is pc at consume: the word after the instruction and its operand
    return_stack #(
        .W     (PC_W),
        .DEPTH (STACK_DEPTH)
    ) u_return_stack (
        .clk       (clk),
        .rst       (reset),
        .push      (do_push),
        .pop       (do_pop),
        .push_data (pc),
        .top_c     (stack_top),
        .err       (stack_err)
    );
`else
    localparam int unsigned unused_stack_depth = STACK_DEPTH;
    logic unused_push_ret;

    assign unused_push_ret = push_ret;
    assign stack_err       = 1'b0;
`endif

    // Next-PC select applied at consume
    always_comb begin
        next_pc = pc;
        if (redirect) begin
            case (pcInMux_ctrl)
                PC_SEL_OPERAND: next_pc = operand[PC_W-1:0];
                PC_SEL_ACC:     next_pc = acc_low;
`ifdef HW_STACK_EN
                PC_SEL_STACK:   next_pc = stack_top;
`endif
                default:        next_pc = pc;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= FETCH;
            pc          <= '0;
            pm_addr     <= '0;
            pm_rd       <= 1'b0;
            instruction <= '0;
            operand     <= '0;
            instr_valid <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    // Out of reset the strobe is not yet up; raise it before moving on
                    if (!pm_rd) begin
                        pm_rd   <= 1'b1;
                        pm_addr <= pc;
                        pc      <= pc + PC_W'(1);
                    end else begin
                        pm_rd <= 1'b0;
                        state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    instruction <= pm_data;
                    operand     <= '0;
                    if (is_two_word(pm_data)) begin
                        pm_rd   <= 1'b1;
                        pm_addr <= pc;
                        pc      <= pc + PC_W'(1);
                        state   <= OPFETCH;
                    end else begin
                        instr_valid <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                OPFETCH: begin
                    pm_rd <= 1'b0;
                    state <= OPCAPTURE;
                end
                OPCAPTURE: begin
                    operand     <= pm_data;
                    instr_valid <= 1'b1;
                    state       <= ISSUE;
                end
                ISSUE: begin
                    // Consume launches the next fetch directly so a redirect target
                    // is on pm_addr in the following cycle
                    if (consume) begin
                        instr_valid <= 1'b0;
                        pm_rd       <= 1'b1;
                        pm_addr     <= next_pc;
                        pc          <= next_pc + PC_W'(1);
                        state       <= FETCH;
                    end
                end
                default: begin
                    pm_rd       <= 1'b0;
                    instr_valid <= 1'b0;
                    state       <= FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_program_sequencer.sv
// Scoreboard bench for program_sequencer: directed program walk, stalls, redirects,
// return stack (when HW_STACK_EN is defined) and mid-operand reset.
module tb_program_sequencer;

    logic        clk;
    logic        reset;
    logic [11:0] pm_addr;
    logic        pm_rd;
    logic [15:0] pm_data;
    logic [15:0] instruction;
    logic [7:0]  OP_dk;
    logic [3:0]  OP_s;
    logic [15:0] operand;
    logic        instr_valid;
    logic        stall;
    logic        redirect;
    logic [1:0]  pc_sel;
    logic [11:0] acc_low;
    logic        push_ret;
    logic        stack_err;

    program_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .pm_addr      (pm_addr),
        .pm_rd        (pm_rd),
        .pm_data      (pm_data),
        .instruction  (instruction),
        .OP_dk        (OP_dk),
        .OP_s         (OP_s),
        .operand      (operand),
        .instr_valid  (instr_valid),
        .stall        (stall),
        .redirect     (redirect),
        .pcInMux_ctrl (pc_sel),
        .acc_low      (acc_low),
        .push_ret     (push_ret),
        .stack_err    (stack_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [15:0] mem [0:4095];

    always @(posedge clk) if (pm_rd) pm_data <= mem[pm_addr];

    typedef struct {
        logic [11:0] addr;
        logic [15:0] instr;
        logic [15:0] opnd;
        int          stall_n;
        logic        redir;
        logic [1:0]  ctrl;
        logic [11:0] acc;
        logic        push;
        logic        err;
    } step_t;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] opnd;
        logic        err;
    } iss_t;

    logic [11:0] exp_fetch [$];
    iss_t        exp_issue [$];
    step_t       steps [$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic step_t mk(input logic [11:0] addr, input logic [15:0] instr,
                                 input logic [15:0] opnd, input int stall_n,
                                 input logic redir, input logic [1:0] ctrl,
                                 input logic [11:0] acc, input logic push, input logic err);
        step_t s;
        s.addr = addr; s.instr = instr; s.opnd = opnd; s.stall_n = stall_n;
        s.redir = redir; s.ctrl = ctrl; s.acc = acc; s.push = push; s.err = err;
        return s;
    endfunction

    task automatic push_exp(input step_t s, input bit with_issue);
        exp_fetch.push_back(s.addr);
        if (s.instr[15:12] == 4'hF) exp_fetch.push_back(s.addr + 12'd1);
        if (with_issue) exp_issue.push_back({s.instr, s.opnd, s.err});
    endtask

    // Monitor: every read strobe and every new issue is checked against the queues
    logic prev_valid = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            prev_valid = 1'b0;
        end else begin
            if (pm_rd) begin
                if (exp_fetch.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_fetch: actual=%h required=none", pm_addr);
                end else begin
                    check("fetch_addr", 32'(pm_addr), 32'(exp_fetch.pop_front()));
                end
            end
            if (instr_valid && !prev_valid) begin
                if (exp_issue.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_issue: actual=%h required=none", instruction);
                end else begin
                    iss_t e;
                    logic [15:0] ei;
                    e  = exp_issue.pop_front();
                    ei = e.instr;
                    check("issue_instr", 32'(instruction), 32'(ei));
                    check("issue_operand", 32'(operand), 32'(e.opnd));
                    check("issue_op_dk", 32'(OP_dk), 32'(ei[15:8]));
                    check("issue_op_s", 32'(OP_s), 32'(ei[15:12]));
                    check("issue_stack_err", 32'(stack_err), 32'(e.err));
                end
            end
            prev_valid = instr_valid;
        end
    end

    // Wait for issue, hold the stall, then consume with the step's execute response
    task automatic run_step(input step_t s, input step_t nxt, input bit nxt_issue);
        int n;
        n = 0;
        while (!instr_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("issue_seen", 32'(instr_valid), 32'd1);
        for (int c = 0; c < s.stall_n; c++) begin
            // Junk on the execute inputs must be ignored while stalled
            redirect = 1'b1; pc_sel = 2'b10; acc_low = 12'h777; push_ret = 1'b1;
            @(negedge clk);
            check("stall_instr", 32'(instruction), 32'(s.instr));
            check("stall_operand", 32'(operand), 32'(s.opnd));
            check("stall_valid", 32'(instr_valid), 32'd1);
            check("stall_pm_rd", 32'(pm_rd), 32'd0);
        end
        push_exp(nxt, nxt_issue);
        redirect = s.redir; pc_sel = s.ctrl; acc_low = s.acc; push_ret = s.push;
        stall = 1'b0;
        @(negedge clk);
        stall = 1'b1; redirect = 1'b0; pc_sel = 2'b00; acc_low = 12'h000; push_ret = 1'b0;
    endtask

    initial begin
        step_t tail;
        step_t restart;
        int    n;

        reset = 1'b1; stall = 1'b1; redirect = 1'b0; pc_sel = 2'b00;
        acc_low = 12'h000; push_ret = 1'b0;

        for (int a = 0; a < 4096; a++) mem[a] = 16'h0000;
        mem[12'h001] = 16'h1234; mem[12'h002] = 16'h2A55;
        mem[12'h003] = 16'hF100; mem[12'h004] = 16'h0005;
        mem[12'h005] = 16'hF900; mem[12'h006] = 16'h0020;
        mem[12'h020] = 16'h3C3C; mem[12'hFFF] = 16'h4001;
        mem[12'h100] = 16'hF800; mem[12'h101] = 16'h0110;
        mem[12'h110] = 16'hF800; mem[12'h111] = 16'h0120;
        mem[12'h120] = 16'hF800; mem[12'h121] = 16'h0130;
        mem[12'h130] = 16'hF800; mem[12'h131] = 16'h0140;
        mem[12'h140] = 16'hF800; mem[12'h141] = 16'h0150;
        mem[12'h150] = 16'hE000; mem[12'h142] = 16'hE000; mem[12'h132] = 16'hE000;
        mem[12'h122] = 16'hE000; mem[12'h112] = 16'hE000; mem[12'h151] = 16'h5A5A;

        //                addr     instr     opnd      st red ctrl   acc      push err
        steps.push_back(mk(12'h000, 16'h0000, 16'h0000, 0, 0, 2'b00, 12'h000, 0, 0));
        steps.push_back(mk(12'h001, 16'h1234, 16'h0000, 0, 1, 2'b00, 12'h000, 0, 0));
        steps.push_back(mk(12'h002, 16'h2A55, 16'h0000, 0, 0, 2'b01, 12'h000, 0, 0));
        steps.push_back(mk(12'h003, 16'hF100, 16'h0005, 0, 1, 2'b01, 12'h000, 0, 0));
        steps.push_back(mk(12'h005, 16'hF900, 16'h0020, 0, 1, 2'b01, 12'h000, 0, 0));
        steps.push_back(mk(12'h020, 16'h3C3C, 16'h0000, 4, 1, 2'b10, 12'hFFF, 0, 0));
        steps.push_back(mk(12'hFFF, 16'h4001, 16'h0000, 0, 0, 2'b00, 12'h000, 0, 0));
        steps.push_back(mk(12'h000, 16'h0000, 16'h0000, 0, 1, 2'b10, 12'h100, 0, 0));
        steps.push_back(mk(12'h100, 16'hF800, 16'h0110, 0, 1, 2'b01, 12'h000, 1, 0));
        steps.push_back(mk(12'h110, 16'hF800, 16'h0120, 0, 1, 2'b01, 12'h000, 1, 0));
        steps.push_back(mk(12'h120, 16'hF800, 16'h0130, 0, 1, 2'b01, 12'h000, 1, 0));
        steps.push_back(mk(12'h130, 16'hF800, 16'h0140, 0, 1, 2'b01, 12'h000, 1, 0));
        steps.push_back(mk(12'h140, 16'hF800, 16'h0150, 0, 1, 2'b01, 12'h000, 1, 0));
`ifdef HW_STACK_EN
        steps.push_back(mk(12'h150, 16'hE000, 16'h0000, 0, 1, 2'b11, 12'h000, 0, 1));
        steps.push_back(mk(12'h142, 16'hE000, 16'h0000, 0, 1, 2'b11, 12'h000, 0, 1));
        steps.push_back(mk(12'h132, 16'hE000, 16'h0000, 0, 1, 2'b11, 12'h000, 0, 1));
        steps.push_back(mk(12'h122, 16'hE000, 16'h0000, 0, 1, 2'b11, 12'h000, 0, 1));
        steps.push_back(mk(12'h112, 16'hE000, 16'h0000, 0, 1, 2'b11, 12'h000, 0, 1));
        steps.push_back(mk(12'h000, 16'h0000, 16'h0000, 0, 1, 2'b10, 12'h003, 0, 1));
`else
        steps.push_back(mk(12'h150, 16'hE000, 16'h0000, 0, 1, 2'b11, 12'h000, 1, 0));
        steps.push_back(mk(12'h151, 16'h5A5A, 16'h0000, 0, 1, 2'b10, 12'h003, 0, 0));
`endif
        tail    = mk(12'h003, 16'hF100, 16'h0005, 0, 0, 2'b00, 12'h000, 0, 0);
        restart = mk(12'h000, 16'h0000, 16'h0000, 0, 0, 2'b00, 12'h000, 0, 0);

        repeat (3) @(negedge clk);
        check("rst_pm_addr", 32'(pm_addr), 32'h0);
        check("rst_pm_rd", 32'(pm_rd), 32'h0);
        check("rst_instruction", 32'(instruction), 32'h0);
        check("rst_operand", 32'(operand), 32'h0);
        check("rst_instr_valid", 32'(instr_valid), 32'h0);
        check("rst_stack_err", 32'(stack_err), 32'h0);

        push_exp(steps[0], 1'b1);
        reset = 1'b0;
        @(negedge clk);
        check("c1_pm_rd", 32'(pm_rd), 32'd1);
        check("c1_pm_addr", 32'(pm_addr), 32'h000);
        @(negedge clk);
        check("c2_instr_valid", 32'(instr_valid), 32'd0);
        @(negedge clk);
        check("c3_instr_valid", 32'(instr_valid), 32'd1);
        check("c3_op_s", 32'(OP_s), 32'h0);

        for (int k = 0; k < steps.size(); k++) begin
            if (k + 1 < steps.size()) run_step(steps[k], steps[k+1], 1'b1);
            else                      run_step(steps[k], tail, 1'b0);
            if (k == 0) begin
                check("c4_pm_addr", 32'(pm_addr), 32'h001);
                check("c4_pm_rd", 32'(pm_rd), 32'd1);
            end
        end

        // Two-word fetch from 003 is in flight; reset lands during the operand capture
        @(negedge clk);
        @(negedge clk);
        check("opfetch_pm_rd", 32'(pm_rd), 32'd1);
        check("opfetch_pm_addr", 32'(pm_addr), 32'h004);
        @(negedge clk);
        check("opcapture_instr", 32'(instruction), 32'hF100);
        reset = 1'b1;
        #1;
        check("midrst_pm_addr", 32'(pm_addr), 32'h0);
        check("midrst_pm_rd", 32'(pm_rd), 32'h0);
        check("midrst_instruction", 32'(instruction), 32'h0);
        check("midrst_operand", 32'(operand), 32'h0);
        check("midrst_instr_valid", 32'(instr_valid), 32'h0);
        check("midrst_stack_err", 32'(stack_err), 32'h0);
        @(negedge clk);
        push_exp(restart, 1'b1);
        reset = 1'b0;

        n = 0;
        while (!instr_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("restart_issue_seen", 32'(instr_valid), 32'd1);
        repeat (2) @(negedge clk);
        check("fetch_queue_drained", 32'(exp_fetch.size()), 32'd0);
        check("issue_queue_drained", 32'(exp_issue.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
